// File: rtl/forth_word_find.sv
// forth_word_find: name -> opcode lookup for the outer interpreter.
// Collects one ASCII token from the parser, scans the primitive name ROM from
// the newest entry (NWORD-1) down to entry 0 and reports the opcode of the
// first entry whose name equals the token, or not-found.
//
// Timing summary, counting cycle 0 as the first cycle in SCAN:
//   - ROM address NWORD-1 is presented in cycle 0, one lower each cycle.
//   - The ROM answers one cycle after rom_en, so entry issued in cycle t
//     is compared in cycle t+1.
//   - A hit in cycle t+1 raises res_valid in cycle t+2.
// Overlong tokens never touch the ROM; the not-found result appears the
// cycle after ch_last is accepted.

module forth_word_find #(
  parameter int NWORD   = 128,
  parameter int AW      = 7,
  parameter int MAX_LEN = 16,
  parameter int UCASE   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  // token character stream from the tokenizer
  input  logic                 ch_valid,
  input  logic [7:0]           ch_data,
  input  logic                 ch_last,
  output logic                 ch_ready,
  // name ROM read port (registered read, data one cycle after rom_en)
  output logic                 rom_en,
  output logic [AW-1:0]        rom_addr,
  input  logic [4:0]           rom_len,
  input  logic [7:0]           rom_op,
  input  logic [8*MAX_LEN-1:0] rom_name,
  // lookup result towards the dispatcher
  output logic                 res_valid,
  output logic                 res_found,
  output logic [7:0]           res_op,
  input  logic                 res_ready
);

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_SCAN    = 2'd1,
    ST_RESULT  = 2'd2
  } state_e;

  state_e          state_q;
  logic [4:0]      len_q;        // chars stored so far (0..MAX_LEN)
  logic            ovf_q;        // token exceeded MAX_LEN, lookup skipped
  logic            ch_ready_q;
  logic            rom_en_q;
  logic [AW-1:0]   rom_addr_q;
  logic            cmp_valid_q;  // ROM outputs this cycle belong to an issued read
  logic            cmp_last_q;   // ...and that read was entry 0
  logic            res_valid_q;
  logic            res_found_q;
  logic [7:0]      res_op_q;

  // Fold a-z onto A-Z when the lookup is case-insensitive.
  function automatic logic [7:0] fold_case(input logic [7:0] c);
    if ((UCASE != 0) && (c >= 8'h61) && (c <= 8'h7A)) begin
      return c - 8'h20;
    end
    return c;
  endfunction

  logic                accept;       // a token char is taken this cycle
  logic                buf_full;     // no room for another char
  logic                ovf_d;        // overflow state including this char
  logic [MAX_LEN-1:0]  char_eq;      // per-position compare, positions >= len pass
  logic                entry_match;  // ROM entry on the bus equals the token
  logic                at_entry0;    // the read being issued is entry 0

  // ch_ready_q is only high in COLLECT, so accept implies COLLECT.
  assign accept   = ch_valid & ch_ready_q;
  assign buf_full = (len_q == 5'(MAX_LEN));
  assign ovf_d    = ovf_q | buf_full;
  assign at_entry0 = (rom_addr_q == '0);

  // One storage byte and one comparator per token position. The token is
  // case-folded on the way in so only the ROM side is folded per compare.
  generate
    for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_pos
      logic [7:0] chr_q;

      // Capture the char that lands at position gi of the token.
      always_ff @(posedge clk) begin
        if (accept && (len_q == 5'(gi))) begin
          chr_q <= fold_case(ch_data);
        end
      end

      assign char_eq[gi] = (5'(gi) >= len_q) ||
                           (chr_q == fold_case(rom_name[8*gi +: 8]));
    end
  endgenerate

  // Empty ROM slots (length 0) can never match; length must be exact.
  assign entry_match = cmp_valid_q &&
                       (rom_len != 5'd0) &&
                       (rom_len == len_q) &&
                       (&char_eq);

  // Control FSM: COLLECT -> SCAN -> RESULT -> COLLECT, all outputs registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_COLLECT;
      len_q       <= 5'd0;
      ovf_q       <= 1'b0;
      ch_ready_q  <= 1'b1;
      rom_en_q    <= 1'b0;
      rom_addr_q  <= '0;
      cmp_valid_q <= 1'b0;
      cmp_last_q  <= 1'b0;
      res_valid_q <= 1'b0;
      res_found_q <= 1'b0;
      res_op_q    <= 8'h00;
    end else begin
      case (state_q)
        ST_COLLECT: begin
          if (accept) begin
            // Chars beyond MAX_LEN are dropped but remembered as overflow.
            if (!buf_full) begin
              len_q <= len_q + 5'd1;
            end else begin
              ovf_q <= 1'b1;
            end
            if (ch_last) begin
              ch_ready_q <= 1'b0;
              if (ovf_d) begin
                // Too long to be any name: answer without touching the ROM.
                state_q     <= ST_RESULT;
                res_valid_q <= 1'b1;
                res_found_q <= 1'b0;
                res_op_q    <= 8'h00;
              end else begin
                // Newest entry is read first, in the first SCAN cycle.
                state_q     <= ST_SCAN;
                rom_en_q    <= 1'b1;
                rom_addr_q  <= AW'(NWORD - 1);
                cmp_valid_q <= 1'b0;
                cmp_last_q  <= 1'b0;
              end
            end
          end
        end

        ST_SCAN: begin
          // Track which issued read the ROM will answer next cycle.
          cmp_valid_q <= rom_en_q;
          cmp_last_q  <= rom_en_q & at_entry0;
          if (entry_match) begin
            // First hit is the newest definition; the read still in flight
            // is simply never looked at.
            state_q     <= ST_RESULT;
            rom_en_q    <= 1'b0;
            cmp_valid_q <= 1'b0;
            res_valid_q <= 1'b1;
            res_found_q <= 1'b1;
            res_op_q    <= rom_op;
          end else if (cmp_valid_q && cmp_last_q) begin
            // Entry 0 compared without a hit.
            state_q     <= ST_RESULT;
            cmp_valid_q <= 1'b0;
            res_valid_q <= 1'b1;
            res_found_q <= 1'b0;
            res_op_q    <= 8'h00;
          end else if (rom_en_q) begin
            // Walk downwards; stop issuing after entry 0, address holds.
            if (at_entry0) begin
              rom_en_q <= 1'b0;
            end else begin
              rom_addr_q <= rom_addr_q - AW'(1);
            end
          end
        end

        ST_RESULT: begin
          // Hold the answer until the dispatcher takes it.
          if (res_ready) begin
            state_q     <= ST_COLLECT;
            res_valid_q <= 1'b0;
            ch_ready_q  <= 1'b1;
            len_q       <= 5'd0;
            ovf_q       <= 1'b0;
          end
        end

        default: begin
          state_q <= ST_COLLECT;
        end
      endcase
    end
  end

  assign ch_ready  = ch_ready_q;
  assign rom_en    = rom_en_q;
  assign rom_addr  = rom_addr_q;
  assign res_valid = res_valid_q;
  assign res_found = res_found_q;
  assign res_op    = res_op_q;

endmodule

// File: tb/tb_forth_word_find.sv
// Bench for forth_word_find: two instances (case-insensitive and exact)
// fed the same token stream, a behavioural ROM with registered read, a
// string-level reference lookup and a queue-based result scoreboard.

module tb_forth_word_find;

  localparam int NWORD   = 128;
  localparam int AW      = 7;
  localparam int MAX_LEN = 16;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 ch_valid = 1'b0;
  logic [7:0]           ch_data = 8'h00;
  logic                 ch_last = 1'b0;

  // index 0: UCASE=1 instance, index 1: UCASE=0 instance
  logic                 ch_ready   [2];
  logic                 rom_en     [2];
  logic [AW-1:0]        rom_addr   [2];
  logic [4:0]           rom_len_r  [2] = '{5'd0, 5'd0};
  logic [7:0]           rom_op_r   [2] = '{8'd0, 8'd0};
  logic [8*MAX_LEN-1:0] rom_name_r [2] = '{'0, '0};
  logic                 res_valid  [2];
  logic                 res_found  [2];
  logic [7:0]           res_op     [2];
  logic                 res_ready  [2];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  forth_word_find #(.NWORD(NWORD), .AW(AW), .MAX_LEN(MAX_LEN), .UCASE(1)) u_ci (
    .clk(clk), .rst_n(rst_n),
    .ch_valid(ch_valid), .ch_data(ch_data), .ch_last(ch_last), .ch_ready(ch_ready[0]),
    .rom_en(rom_en[0]), .rom_addr(rom_addr[0]),
    .rom_len(rom_len_r[0]), .rom_op(rom_op_r[0]), .rom_name(rom_name_r[0]),
    .res_valid(res_valid[0]), .res_found(res_found[0]), .res_op(res_op[0]),
    .res_ready(res_ready[0])
  );

  forth_word_find #(.NWORD(NWORD), .AW(AW), .MAX_LEN(MAX_LEN), .UCASE(0)) u_cs (
    .clk(clk), .rst_n(rst_n),
    .ch_valid(ch_valid), .ch_data(ch_data), .ch_last(ch_last), .ch_ready(ch_ready[1]),
    .rom_en(rom_en[1]), .rom_addr(rom_addr[1]),
    .rom_len(rom_len_r[1]), .rom_op(rom_op_r[1]), .rom_name(rom_name_r[1]),
    .res_valid(res_valid[1]), .res_found(res_found[1]), .res_op(res_op[1]),
    .res_ready(res_ready[1])
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- name ROM model ----------------
  string                rom_str [NWORD];
  logic [7:0]           rom_op_m[NWORD];
  logic [8*MAX_LEN-1:0] rom_pad [NWORD];

  function automatic logic [8*MAX_LEN-1:0] rom_bits(input int i);
    logic [8*MAX_LEN-1:0] v;
    v = rom_pad[i];
    for (int k = 0; k < rom_str[i].len(); k++) v[8*k +: 8] = rom_str[i].getc(k);
    return v;
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rom_en[d]) begin
        rom_len_r[d]  <= 5'(rom_str[rom_addr[d]].len());
        rom_op_r[d]   <= rom_op_m[rom_addr[d]];
        rom_name_r[d] <= rom_bits(int'(rom_addr[d]));
      end
    end
  end

  function automatic string rand_str(input int n, input string cs);
    string s;
    s = "";
    for (int k = 0; k < n; k++) s = {s, "?"};
    for (int k = 0; k < n; k++) s.putc(k, cs.getc($urandom_range(0, cs.len() - 1)));
    return s;
  endfunction

  task automatic set_entry(input int i, input string name, input logic [7:0] op);
    rom_str[i]  = name;
    rom_op_m[i] = op;
  endtask

  task automatic rom_init();
    string up;
    up = "ABCDEFGHIJKLMNOPQRSTUVWXYZ0123456789+-*/<>=@!";
    for (int i = 0; i < NWORD; i++) begin
      rom_str[i]  = "";
      rom_op_m[i] = 8'($urandom);
      rom_pad[i]  = {$urandom, $urandom, $urandom, $urandom};
    end
    // random long names in the upper region, some duplicated upwards
    for (int i = 8'h30; i < NWORD - 1; i++) begin
      if ($urandom_range(0, 9) < 6) begin
        if (($urandom_range(0, 7) == 0) && (rom_str[i-1].len() != 0))
          set_entry(i, rom_str[i-1], 8'($urandom));
        else
          set_entry(i, rand_str($urandom_range(5, MAX_LEN), up), 8'($urandom));
      end
    end
    // primitives at index = opcode
    set_entry(8'h00, "NOP", 8'h00);
    set_entry(8'h05, "ABCDEFGHIJKLMNOP", 8'h05);
    set_entry(8'h12, "DUP", 8'h12);
    set_entry(8'h13, "DROP", 8'h13);
    set_entry(8'h14, "SWAP", 8'h14);
    set_entry(8'h15, "OVER", 8'h15);
    set_entry(8'h18, "+", 8'h18);
    set_entry(8'h19, "-", 8'h19);
    set_entry(8'h20, "@", 8'h20);
    set_entry(8'h21, "!", 8'h21);
    set_entry(NWORD - 1, "TOPWORD", 8'h7E);
  endtask

  // ---------------- reference lookup ----------------
  // Newest-first search over name strings; overlong tokens never match.
  function automatic void model(input string tok, input bit ucase,
                                output bit found, output logic [7:0] op, output int idx);
    string a, b;
    found = 1'b0;
    op    = 8'h00;
    idx   = -1;
    if (tok.len() > MAX_LEN) return;
    for (int i = NWORD - 1; i >= 0; i--) begin
      a = tok;
      b = rom_str[i];
      if (ucase) begin
        a = a.toupper();
        b = b.toupper();
      end
      if ((b.len() != 0) && (a == b)) begin
        found = 1'b1;
        op    = rom_op_m[i];
        idx   = i;
        return;
      end
    end
  endfunction

  typedef struct {
    bit         found;
    bit         ovf;
    logic [7:0] op;
    int         lat;    // cycles from the ch_last accept edge to first res_valid sample
    int         acc;
    int         stall;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s dut%0d: got %0h expected %0h", name, d, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    for (int d = 0; d < 2; d++) begin
      check({tag, "_ch_ready"},  d, 32'(ch_ready[d]),  32'd1);
      check({tag, "_rom_en"},    d, 32'(rom_en[d]),    32'd0);
      check({tag, "_rom_addr"},  d, 32'(rom_addr[d]),  32'd0);
      check({tag, "_res_valid"}, d, 32'(res_valid[d]), 32'd0);
      check({tag, "_res_found"}, d, 32'(res_found[d]), 32'd0);
      check({tag, "_res_op"},    d, 32'(res_op[d]),    32'd0);
    end
  endtask

  // ---------------- driver ----------------
  task automatic wait_idle();
    while (!(ch_ready[0] && ch_ready[1])) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_token(input string tok, input int stall, input bit expect_res);
    int   n, acc, idx;
    bit   f;
    logic [7:0] op;
    exp_t e;
    wait_idle();
    n = tok.len();
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        ch_valid = 1'b0;
        @(posedge clk); #1;
      end
      ch_valid = 1'b1;
      ch_data  = tok.getc(k);
      ch_last  = (k == n - 1);
      @(posedge clk); #1;
    end
    ch_valid = 1'b0;
    ch_last  = 1'b0;
    acc = cyc;
    if (expect_res) begin
      for (int d = 0; d < 2; d++) begin
        model(tok, (d == 0), f, op, idx);
        e.found = f;
        e.op    = op;
        e.ovf   = (n > MAX_LEN);
        e.acc   = acc;
        e.stall = stall;
        if (e.ovf)   e.lat = 0;
        else if (f)  e.lat = NWORD + 1 - idx;
        else         e.lat = NWORD + 1;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
      end
    end
  endtask

  function automatic string rand_token();
    string s;
    string cs;
    int    i, n;
    byte   c;
    cs = "ABCDEFGHIJKLMNOPQRSTUVWXYZabcdefghijklmnopqrstuvwxyz0123456789+-*/<>=@!";
    case ($urandom_range(0, 4))
      0, 1: begin
        do i = $urandom_range(0, NWORD - 1); while (rom_str[i].len() == 0);
        s = rom_str[i];
        for (int k = 0; k < s.len(); k++) begin
          c = s.getc(k);
          if ((c >= 8'h41) && (c <= 8'h5A) && ($urandom_range(0, 2) == 0)) s.putc(k, c + 8'h20);
        end
      end
      2: begin
        do i = $urandom_range(0, NWORD - 1); while (rom_str[i].len() < 2);
        s = rom_str[i].substr(0, rom_str[i].len() - 2);
      end
      3: begin
        n = $urandom_range(1, MAX_LEN);
        s = rand_str(n, cs);
      end
      default: begin
        n = $urandom_range(MAX_LEN + 1, MAX_LEN + 4);
        s = rand_str(n, cs);
      end
    endcase
    return s;
  endfunction

  initial begin
    rom_init();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    rst_n = 1'b1;

    // directed lookups
    send_token("DUP", 0, 1);
    send_token("dup", 0, 1);
    send_token("+", 0, 1);
    send_token("XYZ", 0, 1);
    send_token("DU", 0, 1);
    send_token("ABCDEFGHIJKLMNOPQ", 0, 1);
    send_token("ABCDEFGHIJKLMNOP", 0, 1);
    send_token("NOP", 0, 1);
    send_token("TOPWORD", 0, 1);
    send_token("Drop", 0, 1);

    // randomized lookups
    for (int t = 0; t < 40; t++) send_token(rand_token(), 0, 1);

    // newer duplicate shadows the primitive; hold the result for 5 cycles
    wait_idle();
    set_entry(100, "DUP", 8'h7F);
    send_token("DUP", 5, 1);
    send_token("dUp", 0, 1);

    // reset in the middle of a scan aborts without a result
    send_token("DUP", 0, 0);
    repeat (10) begin
      @(posedge clk); #1;
    end
    for (int d = 0; d < 2; d++) check("scan_busy_rom_en", d, 32'(rom_en[d]), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_reset("midscan");
    rst_n = 1'b1;
    send_token("DROP", 0, 1);

    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++)
      check("queue_drained", d, 32'((d == 0) ? q0.size() : q1.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // ---------------- monitor / scoreboard ----------------
  exp_t       cur         [2];
  bit         active      [2];
  bit         rom_seen    [2];
  bit         chk_next    [2];
  int         stall_cnt   [2];
  bit         first_found [2];
  logic [7:0] first_op    [2];

  initial begin
    for (int d = 0; d < 2; d++) begin
      res_ready[d] = 1'b0;
      active[d]    = 1'b0;
      rom_seen[d]  = 1'b0;
      chk_next[d]  = 1'b0;
      stall_cnt[d] = 0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (!rst_n) begin
          active[d]   = 1'b0;
          rom_seen[d] = 1'b0;
          chk_next[d] = 1'b0;
          continue;
        end
        if (rom_en[d]) rom_seen[d] = 1'b1;
        if (chk_next[d]) begin
          check("ready_after_take", d, 32'(ch_ready[d]), 32'd1);
          check("valid_after_take", d, 32'(res_valid[d]), 32'd0);
          chk_next[d] = 1'b0;
        end
        if (res_valid[d]) begin
          if (!active[d]) begin
            if (((d == 0) ? q0.size() : q1.size()) == 0) begin
              tests++;
              fails++;
              $display("FAIL unexpected_result dut%0d: got res_valid 1 expected none", d);
              res_ready[d] = 1'b1;
              continue;
            end
            if (d == 0) cur[d] = q0[0];
            else        cur[d] = q1[0];
            active[d]      = 1'b1;
            stall_cnt[d]   = cur[d].stall;
            first_found[d] = res_found[d];
            first_op[d]    = res_op[d];
            check("latency", d, 32'(cyc - cur[d].acc), 32'(cur[d].lat));
          end else begin
            check("hold_found", d, 32'(res_found[d]), 32'(first_found[d]));
            check("hold_op", d, 32'(res_op[d]), 32'(first_op[d]));
          end
          check("ch_ready_in_result", d, 32'(ch_ready[d]), 32'd0);
          if (stall_cnt[d] > 0) begin
            res_ready[d] = 1'b0;
            stall_cnt[d]--;
          end else begin
            res_ready[d] = ($urandom_range(0, 2) != 0);
          end
          if (res_ready[d]) begin
            check("res_found", d, 32'(res_found[d]), 32'(cur[d].found));
            check("res_op", d, 32'(res_op[d]), 32'(cur[d].op));
            if (cur[d].ovf) check("ovf_no_rom_read", d, 32'(rom_seen[d]), 32'd0);
            $display("[TB] dut%0d result found=%0d op=%02h lat=%0d ovf=%0d",
                     d, res_found[d], res_op[d], cyc - cur[d].acc, cur[d].ovf);
            if (d == 0) void'(q0.pop_front());
            else        void'(q1.pop_front());
            active[d]   = 1'b0;
            rom_seen[d] = 1'b0;
            chk_next[d] = 1'b1;
          end
        end else begin
          res_ready[d] = ($urandom_range(0, 1) == 0);
        end
      end
    end
  end

  // ---------------- run-time bound ----------------
  initial begin
    #600000;
    fails++;
    $display("FAIL watchdog: got no completion expected finish within 60000 cycles");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
